// File: rtl/pipe_data_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pipe_data_mux
//  Purpose  : Registered N:1 data selector with valid/ready handshake on both
//             sides. A 2-entry skid buffer (main + skid register) sustains one
//             beat per clock, and in_ready/out_valid decode only the state
//             register, so there is no combinational out_ready -> in_ready path.
//             An out-of-range select captures RESET_VAL with out_err set.
//  Ports    : clk        clock, rising edge
//             rst_n      asynchronous active-low reset
//             flush      synchronous drop of all buffered beats
//             in_valid   upstream beat present
//             in_ready   block can accept a beat this cycle
//             data_i     NUM_IN*WIDTH flattened inputs, input k at [k*WIDTH +: WIDTH]
//             sel_i      input index, sampled with the beat
//             out_valid  out_data/out_err hold a beat
//             out_ready  downstream takes the beat
//             out_data   selected data (registered)
//             out_err    beat was captured with sel_i >= NUM_IN
//  Revision : 1.0  initial release
// ============================================================================
module pipe_data_mux #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              SEL_W     = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_IN*WIDTH-1:0]   data_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err
);

  localparam logic [1:0] c_st_empty = 2'd0;  // no entries
  localparam logic [1:0] c_st_hold  = 2'd1;  // main only
  localparam logic [1:0] c_st_full  = 2'd2;  // main + skid

  // One extra bit so NUM_IN itself is representable when NUM_IN is a power of two.
  localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_main_data;
  logic             r_main_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_pop;

  // The loop only ever touches indices below NUM_IN, so an out-of-range
  // select falls through to RESET_VAL without reading past data_i.
  always_comb begin
    w_sel_data = RESET_VAL;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        w_sel_data = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_sel_err = ({1'b0, sel_i} >= c_num_in);

  assign in_ready  = (r_state != c_st_full);
  assign out_valid = (r_state != c_st_empty);
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_data  = r_main_data;
  assign out_err   = r_main_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_empty;
      r_main_data <= RESET_VAL;
      r_main_err  <= 1'b0;
      r_skid_data <= RESET_VAL;
      r_skid_err  <= 1'b0;
    end else if (flush) begin
      // Flush wins over accept and pop; a beat offered this cycle is dropped
      // even though upstream sees its handshake complete.
      r_state <= c_st_empty;
    end else begin
      case (r_state)
        c_st_empty: begin
          if (w_accept) begin
            r_main_data <= w_sel_data;
            r_main_err  <= w_sel_err;
            r_state     <= c_st_hold;
          end
        end
        c_st_hold: begin
          if (w_accept && w_pop) begin
            r_main_data <= w_sel_data;
            r_main_err  <= w_sel_err;
          end else if (w_accept) begin
            // Downstream stalled: park the new beat behind the one on the output.
            r_skid_data <= w_sel_data;
            r_skid_err  <= w_sel_err;
            r_state     <= c_st_full;
          end else if (w_pop) begin
            r_state <= c_st_empty;
          end
        end
        c_st_full: begin
          if (w_pop) begin
            r_main_data <= r_skid_data;
            r_main_err  <= r_skid_err;
            r_state     <= c_st_hold;
          end
        end
        default: begin
          r_state <= c_st_empty;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_data_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_data_mux
//  Purpose  : Self-checking bench for pipe_data_mux. Two instances share all
//             stimulus: a 4-input one (RESET_VAL 0) and a 3-input one
//             (RESET_VAL DEADBEEF) for out-of-range selects. Expected beats are
//             queued when accepted and compared when the DUT pops them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_data_mux;

  localparam int          W   = 32;
  localparam logic [31:0] RV3 = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, flush, in_valid, out_ready;
  logic [4*W-1:0] data_i;
  logic [1:0]     sel_i;
  logic           ir4, ov4, err4, ir3, ov3, err3;
  logic [W-1:0]   od4, od3;

  pipe_data_mux #(.WIDTH(W), .NUM_IN(4), .RESET_VAL(32'h0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
    .data_i(data_i), .sel_i(sel_i), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_err(err4));

  pipe_data_mux #(.WIDTH(W), .NUM_IN(3), .RESET_VAL(RV3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
    .data_i(data_i[3*W-1:0]), .sel_i(sel_i), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .out_err(err3));

  typedef struct packed { logic [31:0] d; logic e; } beat_t;
  typedef struct {
    bit ov; bit ir; logic [31:0] d; logic e;
    bit popped; bit under; beat_t exp; int qsz;
  } samp_t;

  beat_t q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic beat_t model(input bit use3);
    beat_t b;
    int n;
    n = use3 ? 3 : 4;
    if (int'(sel_i) < n) b.d = data_i[int'(sel_i)*W +: W];
    else                 b.d = use3 ? RV3 : 32'h0;
    b.e = (int'(sel_i) >= n);
    return b;
  endfunction

  // Samples the chosen DUT at the falling edge, updates the scoreboard for the
  // coming rising edge, then returns 1ns after that edge. No comparisons here.
  task automatic tick(input bit use3, output samp_t s);
    @(negedge clk);
    s.ov = use3 ? ov3 : ov4;
    s.ir = use3 ? ir3 : ir4;
    s.d  = use3 ? od3 : od4;
    s.e  = use3 ? err3 : err4;
    s.qsz = q.size();
    s.popped = 1'b0; s.under = 1'b0; s.exp = '0;
    if (!flush && s.ov && out_ready) begin
      s.popped = 1'b1;
      if (q.size() == 0) s.under = 1'b1;
      else               s.exp = q.pop_front();
    end
    if (flush) q.delete();
    else if (in_valid && s.ir) q.push_back(model(use3));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    sel_i = '0; data_i = '0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    samp_t s;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    sel_i = 2'd0; data_i = {4{32'h5A5A_5A5A}};
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ov4 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov4); else n_pass++;
    n_total++; if (ir4 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir4); else n_pass++;
    n_total++; if (od4 !== 32'h0) $display("FAIL reset_out_data: got %h want 00000000", od4); else n_pass++;
    n_total++; if (err4 !== 1'b0) $display("FAIL reset_out_err: got %b want 0", err4); else n_pass++;
    n_total++; if (od3 !== RV3) $display("FAIL reset_val3: got %h want %h", od3, RV3); else n_pass++;
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    // Fill to FULL, then reset asynchronously between clock edges.
    in_valid = 1'b1; data_i[31:0] = 32'h1; tick(0, s);
    data_i[31:0] = 32'h2; tick(0, s);
    in_valid = 1'b0; tick(0, s);
    n_total++;
    if ({s.ov, s.ir} !== 2'b10) $display("FAIL reset_pre_full: got ov/ir %b%b want 10", s.ov, s.ir);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (ov4 !== 1'b0) $display("FAIL async_out_valid: got %b want 0", ov4); else n_pass++;
    n_total++; if (ir4 !== 1'b1) $display("FAIL async_in_ready: got %b want 1", ir4); else n_pass++;
    n_total++; if (od4 !== 32'h0) $display("FAIL async_out_data: got %h want 00000000", od4); else n_pass++;
    do_reset();
  endtask

  task automatic test_select_sweep();
    samp_t s;
    do_reset();
    out_ready = 1'b1;
    data_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    for (int i = 0; i <= 4; i++) begin
      in_valid = (i < 4);
      sel_i = 2'(i);
      tick(0, s);
      if (i == 0) begin
        n_total++; if (s.ov !== 1'b0) $display("FAIL sweep_empty: got out_valid %b want 0", s.ov); else n_pass++;
      end else begin
        n_total++;
        if (!s.popped || s.d !== 32'h1111_1111 * i)
          $display("FAIL sweep_sel%0d: got valid %b data %h want valid 1 data %h", i-1, s.popped, s.d, 32'h1111_1111 * i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall_skid();
    samp_t s;
    do_reset();
    sel_i = 2'd0;
    in_valid = 1'b1; data_i[31:0] = 32'hA; tick(0, s);
    data_i[31:0] = 32'hB; tick(0, s);
    in_valid = 1'b0; tick(0, s);
    n_total++; if (s.ir !== 1'b0) $display("FAIL skid_full_ready: got %b want 0", s.ir); else n_pass++;
    n_total++; if (s.d !== 32'hA) $display("FAIL skid_hold_data: got %h want 0000000a", s.d); else n_pass++;
    out_ready = 1'b1;
    tick(0, s);
    n_total++; if (!s.popped || s.d !== 32'hA) $display("FAIL skid_pop_a: got %b/%h want 1/0000000a", s.popped, s.d); else n_pass++;
    tick(0, s);
    n_total++; if (!s.popped || s.d !== 32'hB) $display("FAIL skid_pop_b: got %b/%h want 1/0000000b", s.popped, s.d); else n_pass++;
    tick(0, s);
    n_total++;
    if ({s.ov, s.ir} !== 2'b01) $display("FAIL skid_drained: got ov/ir %b%b want 01", s.ov, s.ir);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    samp_t s;
    do_reset();
    out_ready = 1'b1;
    data_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    in_valid = 1'b1; sel_i = 2'd3; tick(1, s);
    sel_i = 2'd1; tick(1, s);
    n_total++;
    if (!s.popped || s.d !== RV3 || s.e !== 1'b1)
      $display("FAIL oor_beat: got %b/%h/%b want 1/%h/1", s.popped, s.d, s.e, RV3);
    else n_pass++;
    in_valid = 1'b0; tick(1, s);
    n_total++;
    if (!s.popped || s.d !== 32'h2222_2222 || s.e !== 1'b0)
      $display("FAIL oor_next_inrange: got %b/%h/%b want 1/22222222/0", s.popped, s.d, s.e);
    else n_pass++;
  endtask

  task automatic test_flush();
    samp_t s;
    do_reset();
    sel_i = 2'd0;
    in_valid = 1'b1; data_i[31:0] = 32'h1; tick(0, s);
    data_i[31:0] = 32'h2; tick(0, s);
    data_i[31:0] = 32'hC; flush = 1'b1; tick(0, s);
    n_total++; if (s.ir !== 1'b0) $display("FAIL flush_full_before: got in_ready %b want 0", s.ir); else n_pass++;
    flush = 1'b0; in_valid = 1'b0; tick(0, s);
    n_total++;
    if ({s.ov, s.ir} !== 2'b01) $display("FAIL flush_empty: got ov/ir %b%b want 01", s.ov, s.ir);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, s);
      n_total++; if (s.ov !== 1'b0) $display("FAIL flush_no_beat%0d: got out_valid %b data %h want 0", i, s.ov, s.d); else n_pass++;
    end
    in_valid = 1'b1; data_i[31:0] = 32'hD; tick(0, s);
    in_valid = 1'b0; tick(0, s);
    n_total++; if (!s.popped || s.d !== 32'hD) $display("FAIL flush_after_beat: got %b/%h want 1/0000000d", s.popped, s.d); else n_pass++;
  endtask

  task automatic test_random();
    samp_t s;
    int acc, cyc;
    logic ir_before;
    do_reset();
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel_i     = 2'($urandom_range(0, 3));
      data_i    = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 255) == 0);
      #1 ir_before = ir3;
      out_ready = ~out_ready;
      #1;
      n_total++; if (ir3 !== ir_before) $display("FAIL rand_comb_path: in_ready %b -> %b on out_ready toggle", ir_before, ir3); else n_pass++;
      out_ready = ~out_ready;
      tick(1, s);
      cyc++;
      if (in_valid && s.ir && !flush) acc++;
      n_total++;
      if ({s.ov, s.ir} !== {s.qsz > 0, s.qsz < 2})
        $display("FAIL rand_occupancy: got ov/ir %b%b want %b%b (entries %0d)", s.ov, s.ir, s.qsz > 0, s.qsz < 2, s.qsz);
      else n_pass++;
      if (s.popped) begin
        n_total++;
        if (s.under || s.d !== s.exp.d || s.e !== s.exp.e)
          $display("FAIL rand_beat: got %h/%b want %h/%b (spurious %b)", s.d, s.e, s.exp.d, s.exp.e, s.under);
        else n_pass++;
      end
    end
    n_total++; if (acc < 10000) $display("FAIL rand_budget: got %0d beats want 10000", acc); else n_pass++;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1, s);
      if (s.popped) begin
        n_total++;
        if (s.under || s.d !== s.exp.d || s.e !== s.exp.e)
          $display("FAIL rand_drain: got %h/%b want %h/%b", s.d, s.e, s.exp.d, s.exp.e);
        else n_pass++;
      end
    end
    n_total++;
    if (q.size() != 0 || ov3 !== 1'b0) $display("FAIL rand_leftover: got %0d entries valid %b want 0/0", q.size(), ov3);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sel_i = '0; data_i = '0;
    test_reset();
    test_select_sweep();
    test_stall_skid();
    test_out_of_range();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
